// File: rtl/mux_rr_arbiter_four_pkg.sv
// ----------------------------------------------------------------------------
// mux_rr_arbiter_four_pkg
//   Shared definitions for the four-way round-robin mux arbiter and its
//   rotating-priority picker.
//
//   Contents:
//     NUM_REQ        number of requesters (4)
//     IDX_W          width of a requester index (2)
//     arb_state_t    arbiter state encoding (ST_IDLE = 0, ST_GRANT = 1)
//     idx_to_onehot  binary requester index -> one-hot grant vector
// ----------------------------------------------------------------------------
package mux_rr_arbiter_four_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_four_pick.sv
// ----------------------------------------------------------------------------
// rr_pick_four
//   Combinational rotating-priority picker for four requesters. The search
//   order is ptr+1, ptr+2, ptr+3, ptr (modulo 4), so the requester that won
//   last time has the lowest priority.
//
//   Ports:
//     i_req   [3:0]  request vector, bit n is requester n
//     i_ptr   [1:0]  index of the previous winner
//     o_idx   [1:0]  index of the chosen requester (i_ptr when none found)
//     o_found        high when at least one request is asserted
// ----------------------------------------------------------------------------
module rr_pick_four
    import mux_rr_arbiter_four_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    logic [IDX_W-1:0] w_cand;

    // Walk the search order from lowest to highest priority so the last hit
    // written is the highest-priority asserted request. The 2-bit add wraps
    // naturally, and offset 4 truncates to 0, i.e. the pointer itself.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it a
        // no-request cycle would leave o_idx/o_found unassigned and infer latches.
        o_idx   = i_ptr;
        o_found = 1'b0;
        w_cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = i_ptr + IDX_W'(k);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter_four.sv
// ----------------------------------------------------------------------------
// mux_rr_arbiter_four
//   Round-robin arbiter that owns the select of a shared four-input mux.
//   A granted requester keeps the mux for as long as it holds its request
//   (locked transfer); a release always costs one idle cycle before the next
//   owner is chosen. No data passes through this block.
//
//   Optional feature (compile-time macro ARB_HOLD_LIMIT_EN):
//     When defined, an owner is force-released after HOLD_MAX consecutive
//     grant cycles even if it is still requesting; rotation then moves on.
//     When undefined, no hold counter exists and grants last indefinitely.
//
//   Parameters:
//     HOLD_MAX   maximum consecutive grant cycles per owner (1..255),
//                only meaningful with ARB_HOLD_LIMIT_EN
//     CNT_W      hold counter width, 2**CNT_W must exceed HOLD_MAX
//
//   Ports:
//     iClk       clock, all state changes on the rising edge
//     iRst       synchronous active-high reset
//     iReq [3:0] per-requester request, held until served
//     oGnt [3:0] registered one-hot grant, zero while idle
//     oSel [1:0] registered binary mux select; holds its last value while
//                idle and is only meaningful when oValid is high
//     oValid     high while a grant is active (OR of oGnt)
//     oNewOwner  one-cycle pulse on the first cycle of each grant
// ----------------------------------------------------------------------------
module mux_rr_arbiter_four
    import mux_rr_arbiter_four_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
)
(
    input  logic               iClk,
    input  logic               iRst,
    input  logic [NUM_REQ-1:0] iReq,
    output logic [NUM_REQ-1:0] oGnt,
    output logic [IDX_W-1:0]   oSel,
    output logic               oValid,
    output logic               oNewOwner
);

    // Reject configurations the hold counter cannot represent.
    if ((HOLD_MAX < 1) || (HOLD_MAX > 255) ||
        ((64'd1 << CNT_W) <= 64'(HOLD_MAX))) begin : g_bad_cfg
        $error("mux_rr_arbiter_four: HOLD_MAX must be 1..255 and below 2**CNT_W");
    end

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_sel;
    logic               r_valid;
    logic               r_new_owner;
    logic [IDX_W-1:0]   r_ptr;      // index of the most recent owner

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    arb_state_t         w_state_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0]   w_sel_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_new_owner_nxt;

    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_found;
    logic               w_owner_req;
    logic               w_hold_hit;

    // r_sel always holds the owner's index while in ST_GRANT.
    assign w_owner_req = iReq[r_sel];

    rr_pick_four u_pick (
        .i_req   (iReq),
        .i_ptr   (r_ptr),
        .o_idx   (w_win_idx),
        .o_found (w_win_found)
    );

`ifdef ARB_HOLD_LIMIT_EN
    // r_hold_cnt counts completed grant cycles of the current owner, so the
    // owner's HOLD_MAX-th cycle is the one where it reads HOLD_MAX-1; the
    // edge that would bring it to HOLD_MAX releases the grant and clears it.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;

    assign w_hold_hit = (r_hold_cnt == HOLD_LAST);
`else
    assign w_hold_hit = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state / output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_sel_nxt       = r_sel;
        w_ptr_nxt       = r_ptr;
        w_new_owner_nxt = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        w_hold_cnt_nxt  = r_hold_cnt;
`endif

        unique case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
`ifdef ARB_HOLD_LIMIT_EN
                w_hold_cnt_nxt = '0;
`endif
                if (w_win_found) begin
                    w_state_nxt     = ST_GRANT;
                    w_gnt_nxt       = idx_to_onehot(w_win_idx);
                    w_sel_nxt       = w_win_idx;
                    w_ptr_nxt       = w_win_idx;
                    w_new_owner_nxt = 1'b1;
                end
            end

            ST_GRANT: begin
                // Other requesters never preempt; only the owner dropping
                // its request (or the hold limit) ends the transfer. oSel is
                // left alone so the mux input stays stable through the bubble.
                if (!w_owner_req || w_hold_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
`ifdef ARB_HOLD_LIMIT_EN
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
`endif
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (iRst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_valid     <= 1'b0;
            r_new_owner <= 1'b0;
            // Pointer at the last requester gives requester 0 top priority.
            r_ptr       <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_sel       <= w_sel_nxt;
            r_valid     <= |w_gnt_nxt;
            r_new_owner <= w_new_owner_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end
`endif

    assign oGnt      = r_gnt;
    assign oSel      = r_sel;
    assign oValid    = r_valid;
    assign oNewOwner = r_new_owner;

endmodule

// File: tb/tb_mux_rr_arbiter_four.sv
module tb_mux_rr_arbiter_four;

    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 8;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       iClk = 1'b0;
    logic       iRst;
    logic [3:0] iReq;
    logic [3:0] oGnt;
    logic [1:0] oSel;
    logic       oValid;
    logic       oNewOwner;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    mux_rr_arbiter_four #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iReq      (iReq),
        .oGnt      (oGnt),
        .oSel      (oSel),
        .oValid    (oValid),
        .oNewOwner (oNewOwner)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_g(input string tag, input logic [3:0] g, input logic n);
        check({tag, "_gnt"},   {28'd0, oGnt},   {28'd0, g});
        check({tag, "_valid"}, {31'd0, oValid}, {31'd0, |g});
        check({tag, "_new"},   {31'd0, oNewOwner}, {31'd0, n});
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Reference model: who owns the mux, who owned it last, how long it has
    // held it. Grants are decided by scanning requesters in rotation order.
    // ------------------------------------------------------------------------
    int m_owner;   // -1 when idle
    int m_ptr;
    int m_sel;
    bit m_new;
    int m_held;

    always @(posedge iClk) begin
        if (iRst) begin
            m_owner = -1;
            m_ptr   = 3;
            m_sel   = 0;
            m_new   = 1'b0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            m_new = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (m_owner < 0 && iReq[c]) begin
                    m_owner = c;
                    m_ptr   = c;
                    m_sel   = c;
                    m_new   = 1'b1;
                    m_held  = 0;
                end
            end
        end else begin
            m_new  = 1'b0;
            m_held = m_held + 1;
            if (!iReq[m_owner] || (HOLD_EN && m_held >= HOLD_MAX)) begin
                m_owner = -1;
                m_held  = 0;
            end
        end
    end

    always @(negedge iClk) begin
        if (model_on) begin
            logic [3:0] eg;
            eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            check("model_gnt",   {28'd0, oGnt},      {28'd0, eg});
            check("model_valid", {31'd0, oValid},    {31'd0, (m_owner >= 0)});
            check("model_new",   {31'd0, oNewOwner}, {31'd0, m_new});
            check("model_sel",   {30'd0, oSel},      m_sel);
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------------
    initial begin
        iRst = 1'b1;
        iReq = 4'b1111;

        // Reset held two cycles with everybody requesting.
        tick();
        model_on = 1'b1;
        tick();
        @(negedge iClk);
        exp_g("rst_hold", 4'b0000, 1'b0);
        check("rst_sel", {30'd0, oSel}, 32'd0);
        iRst = 1'b0;
        tick();
        @(negedge iClk);
        exp_g("first_grant", 4'b0001, 1'b1);
        check("first_sel", {30'd0, oSel}, 32'd0);

        // Rotation: each owner keeps two cycles, then drops for one.
        for (int i = 0; i < 5; i++) begin
            int o;
            o = i % 4;
            if (i > 0) begin
                @(negedge iClk);
                exp_g("rot_new", 4'(1 << o), 1'b1);
                check("rot_sel", {30'd0, oSel}, o);
            end
            if (i == 4) break;
            tick();
            iReq = 4'b1111 & ~4'(1 << o);
            @(negedge iClk);
            exp_g("rot_hold", 4'(1 << o), 1'b0);
            tick();
            iReq = 4'b1111;
            @(negedge iClk);
            exp_g("rot_bubble", 4'b0000, 1'b0);
            tick();
        end

        // Restart from reset with requesters 0 and 1.
        iReq = 4'b0011;
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        @(negedge iClk);
        exp_g("hold_rst", 4'b0000, 1'b0);
        tick();
`ifdef ARB_HOLD_LIMIT_EN
        // Force release after HOLD_MAX cycles, alternating 0 and 1.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge iClk);
                exp_g("hold_cyc", 4'(1 << r), c == 0);
                tick();
            end
            @(negedge iClk);
            exp_g("hold_bubble", 4'b0000, 1'b0);
            tick();
        end
        @(negedge iClk);
        exp_g("hold_back", 4'b0001, 1'b1);
`else
        // No limit: requester 0 keeps the grant for as long as it asks.
        for (int c = 0; c < 12; c++) begin
            @(negedge iClk);
            exp_g("nolimit", 4'b0001, c == 0);
            tick();
        end

        // Lock: owner 2 is not preempted by requester 0.
        iReq = 4'b0100;
        tick();
        @(negedge iClk);
        exp_g("lock_pre_bubble", 4'b0000, 1'b0);
        tick();
        iReq = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            @(negedge iClk);
            exp_g("lock_hold", 4'b0100, i == 0);
            tick();
        end
        iReq = 4'b1001;
        @(negedge iClk);
        exp_g("lock_last", 4'b0100, 1'b0);
        tick();
        @(negedge iClk);
        exp_g("lock_bubble", 4'b0000, 1'b0);
        tick();
        @(negedge iClk);
        exp_g("lock_next3", 4'b1000, 1'b1);
        check("lock_sel3", {30'd0, oSel}, 32'd3);
        iReq = 4'b0001;
        tick();
        @(negedge iClk);
        exp_g("lock_bubble2", 4'b0000, 1'b0);
        tick();
        @(negedge iClk);
        exp_g("lock_next0", 4'b0001, 1'b1);
`endif

        // Sparse: pointer at 1, only requester 0 asks.
        iReq = 4'b0010;
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        tick();
        @(negedge iClk);
        exp_g("sparse_g1", 4'b0010, 1'b1);
        iReq = 4'b0001;
        tick();
        @(negedge iClk);
        exp_g("sparse_bubble", 4'b0000, 1'b0);
        check("sparse_sel_keep", {30'd0, oSel}, 32'd1);
        tick();
        @(negedge iClk);
        exp_g("sparse_g0", 4'b0001, 1'b1);
        check("sparse_sel", {30'd0, oSel}, 32'd0);

        // Reset in the middle of requester 1's grant.
        iReq = 4'b0010;
        tick();
        tick();
        @(negedge iClk);
        exp_g("midrst_pre", 4'b0010, 1'b1);
        iRst = 1'b1;
        tick();
        @(negedge iClk);
        exp_g("midrst_drop", 4'b0000, 1'b0);
        check("midrst_sel", {30'd0, oSel}, 32'd0);
        iRst = 1'b0;
        iReq = 4'b1010;
        tick();
        @(negedge iClk);
        exp_g("midrst_regrant", 4'b0010, 1'b1);
        check("midrst_regrant_sel", {30'd0, oSel}, 32'd1);

        // A request pulse between edges while idle is never granted.
        iReq = 4'b0000;
        tick();
        tick();
        #2 iReq = 4'b1000;
        #2 iReq = 4'b0000;
        @(negedge iClk);
        exp_g("glitch_a", 4'b0000, 1'b0);
        tick();
        @(negedge iClk);
        exp_g("glitch_b", 4'b0000, 1'b0);

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
